// File: rtl/sysctrl_bank.sv
// sysctrl_bank: MCU-to-FPGA system control byte-stream parser.
// Provides core status/ID, LEDs, RGB colour, buttons, interrupts and a
// parametrised bank of 8-bit config slots driven from the MCU link.
// Optional feature macro: SYSCTRL_CFG_READBACK_EN enables CMD 6 (config slot
// readback). When it is undefined, CMD 6 is handled as an unknown command.
module sysctrl_bank #(
    parameter logic [7:0]          CORE_ID  = 8'h02,
    parameter int unsigned         NUM_CFG  = 32,
    parameter logic [NUM_CFG*8-1:0] CFG_INIT = '0,
    parameter int unsigned         NUM_LED  = 2,
    parameter int unsigned         NUM_BTN  = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 data_in_strobe,
    input  logic                 data_in_start,
    input  logic [7:0]           data_in,
    output logic [7:0]           data_out,
    output logic                 int_out_n,
    input  logic [7:0]           int_in,
    output logic [7:0]           int_ack,
    input  logic [NUM_BTN-1:0]   buttons,
    output logic [NUM_LED-1:0]   leds,
    output logic [23:0]          color,
    output logic [NUM_CFG*8-1:0] cfg,
    output logic [NUM_CFG-1:0]   cfg_wr
);

    // Command codes carried in the first byte of a frame
    typedef enum logic [7:0] {
        CMD_STATUS = 8'h00,
        CMD_LEDS   = 8'h01,
        CMD_COLOR  = 8'h02,
        CMD_BTNS   = 8'h03,
        CMD_CFG_WR = 8'h04,
        CMD_INT    = 8'h05,
        CMD_CFG_RD = 8'h06
    } cmd_e;

    // Frame position: 0 = idle (no frame), 1..15 = byte index, saturating
    logic [3:0] state;
    logic [7:0] command;
    logic [7:0] ptr;
    logic       coldboot;

    logic [7:0] data_rev;
    logic [7:0] btn_ext;

    // Colour bytes arrive LSB-first; reverse so data_in[0] lands in the MSB
    always_comb begin
        data_rev = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            data_rev[i] = data_in[7-i];
        end
    end

    // Zero-extend the button bank to a full reply byte
    always_comb begin
        btn_ext = '0;
        btn_ext[NUM_BTN-1:0] = buttons;
    end

`ifdef SYSCTRL_CFG_READBACK_EN
    logic [7:0] rd_byte;

    // Slot read mux; pointers beyond the bank read as zero
    always_comb begin
        rd_byte = '0;
        for (int unsigned n = 0; n < NUM_CFG; n++) begin
            if (ptr == 8'(n)) begin
                rd_byte = cfg[8*n +: 8];
            end
        end
    end
`endif

    // Interrupt request: any level source or an unacknowledged cold boot
    always_comb begin
        int_out_n = !((|int_in) | coldboot);
    end

    // Frame parser, register bank and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= '0;
            command  <= '0;
            ptr      <= '0;
            coldboot <= 1'b1;
            data_out <= '0;
            leds     <= '0;
            color    <= '0;
            int_ack  <= '0;
            cfg_wr   <= '0;
            cfg      <= CFG_INIT;
        end else begin
            cfg_wr  <= '0;
            int_ack <= '0;
            if (int_ack[0]) begin
                coldboot <= 1'b0;
            end
            if (data_in_strobe) begin
                if (data_in_start) begin
                    command <= data_in;
                    state   <= 4'd1;
                end else if (state != 4'd0) begin
                    if (state != 4'd15) begin
                        state <= state + 4'd1;
                    end
                    data_out <= 8'h00;
                    case (command)
                        CMD_STATUS: begin
                            case (state)
                                4'd1:    data_out <= 8'h5C;
                                4'd2:    data_out <= 8'h42;
                                4'd3:    data_out <= CORE_ID;
                                4'd4:    data_out <= 8'(NUM_CFG);
                                default: data_out <= 8'h00;
                            endcase
                        end
                        CMD_LEDS: begin
                            if (state == 4'd1) begin
                                leds <= data_in[NUM_LED-1:0];
                            end
                        end
                        CMD_COLOR: begin
                            case (state)
                                4'd1:    color[15:8]  <= data_rev;
                                4'd2:    color[7:0]   <= data_rev;
                                4'd3:    color[23:16] <= data_rev;
                                default: ;
                            endcase
                        end
                        CMD_BTNS: begin
                            data_out <= btn_ext;
                        end
                        CMD_CFG_WR: begin
                            if (state == 4'd1) begin
                                ptr <= data_in;
                            end else begin
                                // Only in-range pointers match a slot; the pointer
                                // advances (and wraps) even when the write is dropped.
                                for (int unsigned n = 0; n < NUM_CFG; n++) begin
                                    if (ptr == 8'(n)) begin
                                        cfg[8*n +: 8] <= data_in;
                                        cfg_wr[n]     <= 1'b1;
                                    end
                                end
                                ptr <= ptr + 8'd1;
                            end
                        end
                        CMD_INT: begin
                            if (state == 4'd1) begin
                                int_ack <= data_in;
                            end
                            data_out <= {int_in[7:1], coldboot};
                        end
`ifdef SYSCTRL_CFG_READBACK_EN
                        CMD_CFG_RD: begin
                            if (state == 4'd1) begin
                                ptr <= data_in;
                            end else begin
                                data_out <= rd_byte;
                                ptr      <= ptr + 8'd1;
                            end
                        end
`endif
                        default: data_out <= 8'h00;
                    endcase
                end
            end
        end
    end

endmodule
